uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the board-level serial path. It samples an asynchronous RXD line on the system clock using an oversampling tick enable, with 3-sample majority voting. It supports configurable frame formats (data bits, parity mode, stop bits) and flags parity and framing errors per word. Received words are buffered in a small FIFO and delivered on a valid/ready interface to downstream logic such as display or command decoders.

## Interface
- CLK_FREQ, 125_000_000: system clock frequency, Hz.
- BAUD_RATE, 9600: line rate, bit/s.
- OVERSAMPLE, 16: ticks per bit; even, 8..32.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: FIFO words, power of 2, ≥2.
- CLK  in  1  system clock, all logic on posedge CLK.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- RXD  in  1  serial line, asynchronous, idle high.
- rx_data  out  DATA_BITS  head-of-FIFO data word, LSB = first received bit.
- rx_perr  out  1  head word parity error; always 0 when PARITY = 0.
- rx_ferr  out  1  head word framing error (a stop bit sampled 0).
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head word when rx_valid & rx_ready.
- overrun  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- RXD passes through a 2-flop synchronizer (rxd_s) before any use, and a third flop provides edge detection.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation. The counter runs 0..DIV-1, and tick is high for one CLK when the count = DIV-1. The counter is forced to 0 on the start-edge cycle to phase-align ticks to the frame.
- Sample counter s_cnt runs 0..OVERSAMPLE-1 and advances on tick. Define MID = OVERSAMPLE/2.
  - rxd_s is captured at s_cnt = MID-1, MID and MID+1.
  - The bit value is the majority of the 3 samples, decided on the MID+1 tick.
- FSM states are IDLE, START, DATA, PAR, STOP.
- IDLE: a falling edge of rxd_s (1→0) moves to START with s_cnt = 0, bit_cnt = 0.
- START: at the decision point:
  - voted 1 means a false start; return to IDLE with no push.
  - voted 0: continue counting to s_cnt = OVERSAMPLE-1, then go to DATA.
- DATA: each voted bit shifts in LSB-first. After DATA_BITS bit periods, go to PAR if PARITY ≠ 0, else STOP.
- PAR: the error flag is perr = (XOR of data ^ voted bit) ≠ (PARITY == 2). Go to STOP after the full bit period.
- STOP: each stop bit that votes 0 sets ferr.
  - On the decision tick of the last stop bit, push {ferr, perr, data} and return to IDLE.
  - This happens at mid-bit, so a start edge in the second half of the stop bit is detected.
- FIFO rules:
  - A push when full is dropped, and overrun pulses for 1 cycle.
  - A push and pop in the same cycle while full is accepted, and overrun stays 0.
  - A pop when empty is ignored.
- Output fields are registered from the head entry. They hold their value while rx_valid & !rx_ready, and are 0 when the FIFO is empty.
- Reset values: rx_data = 0, rx_perr = 0, rx_ferr = 0, rx_valid = 0, overrun = 0, busy = 0, FIFO empty, FSM IDLE.
- Reset mid-frame discards the partial word and all FIFO contents immediately, with no push.

## Timing
- Bit period = OVERSAMPLE*DIV CLK cycles.
- Start-edge latency: 2 synchronizer cycles + 1 edge cycle.
- A pushed word shows rx_valid = 1 on the CLK after the push cycle.
- rx_valid falls on the CLK after the pop of the last entry.
- Back-to-back words: the consumer may pop every cycle.
- busy rises on the cycle after the start edge is detected. It falls on the cycle after the last stop decision.
- overrun aligns to the dropped push cycle +1.

## Test plan
- Test parameters: CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 (DIV = 1, 16 cycles/bit), rx_ready held 1.
- 8N1, send 0x41 → rx_valid pulses once, rx_data = 0x41, perr = 0, ferr = 0, overrun = 0.
- 8E1 → 8O1, send 0x41 with correct even parity (0) under each mode:
  - under PARITY=1, perr = 0;
  - under PARITY=2, the same stimulus gives perr = 1 with data 0x41.
- Stop bit forced 0 on 0x55 → rx_ferr = 1, rx_data = 0x55. Then the next frame 0xAA is received cleanly.
- Glitch handling on 8N1:
  - a 4-cycle low glitch on idle RXD → false start, no rx_valid, busy returns 0;
  - a single-cycle inverted glitch at mid data bit 3 of 0x00 → still 0x00 (majority vote).
- FIFO_DEPTH=4 with rx_ready=0, send 5 words 0x01..0x05:
  - 4 are held, and overrun pulses once at word 5;
  - the pops then return 0x01..0x04 in order.
- Assert RST mid-DATA with 2 words queued → all outputs 0 asynchronously. After release, the next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with majority vote, parity/framing flags and output FIFO
// Frames are sampled mid-bit on three ticks; completed words queue in a small FIFO behind a valid/ready port.
module uart_rx_param #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int MID     = OVERSAMPLE / 2;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int WW      = DATA_BITS + 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MM1    = SW'(MID - 1);
  localparam logic [SW-1:0] S_MID    = SW'(MID);
  localparam logic [SW-1:0] S_MP1    = SW'(MID + 1);
  localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 rxd_m, rxd_s, rxd_d;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        s_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] data_sr;
  logic                 perr, ferr;

  logic start_edge, tick, decide, last_s, vote, push;
  logic [WW-1:0] push_word;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign start_edge = (state == IDLE) && rxd_d && !rxd_s;
  assign tick       = (div_cnt == DIV_LAST);
  assign decide     = tick && (s_cnt == S_MP1);
  assign last_s     = tick && (s_cnt == S_LAST);
  assign vote       = (smp[0] & smp[1]) | (smp[0] & rxd_s) | (smp[1] & rxd_s);
  assign push       = decide && (state == STOP) && (bit_cnt == SB_LAST);
  assign push_word  = {ferr | ~vote, perr, data_sr};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (start_edge || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      smp     <= '0;
      data_sr <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else if (state == IDLE) begin
      if (start_edge) begin
        state   <= START;
        s_cnt   <= '0;
        bit_cnt <= '0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
        busy    <= 1'b1;
      end
    end else if (tick) begin
      s_cnt <= last_s ? '0 : s_cnt + 1'b1;
      if (s_cnt == S_MM1) smp[0] <= rxd_s;
      if (s_cnt == S_MID) smp[1] <= rxd_s;
      case (state)
        START: begin
          if (decide && vote) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (decide) data_sr <= {vote, data_sr[DATA_BITS-1:1]};
          if (last_s) begin
            if (bit_cnt == DB_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (decide) perr <= ((^data_sr) ^ vote) != (PARITY == 2);
          if (last_s) state <= STOP;
        end
        STOP: begin
          // The word is committed at mid-bit so a following start edge is not missed.
          if (decide) begin
            if (!vote) ferr <= 1'b1;
            if (bit_cnt == SB_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (last_s) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic [WW-1:0] head_n;
  logic          pop, full, push_ok;

  assign pop     = rx_valid & rx_ready;
  assign full    = (count == FULL_CNT);
  assign push_ok = push && (!full || pop);

  // Output registers take the next head so they track the FIFO without a bubble.
  always_comb begin
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    head_n   = (push_ok && (wr_ptr == rd_ptr_n)) ? push_word : mem[rd_ptr_n];
    if (count_n == '0) head_n = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rx_valid <= (count_n != '0);
      {rx_ferr, rx_perr, rx_data} <= head_n;
      overrun  <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed scoreboard bench for uart_rx_param
// One 8N1 receiver is scoreboarded; 8E1/8O1 receivers share a parity line.
module tb_uart_rx_param;

  logic CLK = 1'b0;
  logic RST;
  logic rxd_n, rxd_p;
  logic rx_ready_n;
  logic rx_ready_p;

  logic [7:0] n_data, e_data, o_data;
  logic n_perr, n_ferr, n_valid, n_ovr, n_busy;
  logic e_perr, e_ferr, e_valid, e_ovr, e_busy;
  logic o_perr, o_ferr, o_valid, o_ovr, o_busy;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int e_cnt = 0;
  int o_cnt = 0;
  logic [9:0] e_word, o_word;
  logic [9:0] sb [$];

  always #5 CLK = ~CLK;

  uart_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
    .CLK(CLK), .RST(RST), .RXD(rxd_n), .rx_data(n_data), .rx_perr(n_perr),
    .rx_ferr(n_ferr), .rx_valid(n_valid), .rx_ready(rx_ready_n), .overrun(n_ovr), .busy(n_busy));

  uart_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .CLK(CLK), .RST(RST), .RXD(rxd_p), .rx_data(e_data), .rx_perr(e_perr),
    .rx_ferr(e_ferr), .rx_valid(e_valid), .rx_ready(rx_ready_p), .overrun(e_ovr), .busy(e_busy));

  uart_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .CLK(CLK), .RST(RST), .RXD(rxd_p), .rx_data(o_data), .rx_perr(o_perr),
    .rx_ferr(o_ferr), .rx_valid(o_valid), .rx_ready(rx_ready_p), .overrun(o_ovr), .busy(o_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every word the 8N1 receiver hands over must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && n_valid && rx_ready_n) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", {n_ferr, n_perr, n_data});
      end else begin
        chk("word", {22'd0, n_ferr, n_perr, n_data}, {22'd0, sb.pop_front()});
      end
    end
    if (!RST && n_ovr) ovr_cnt++;
    if (!RST && e_valid) begin e_cnt++; e_word = {e_ferr, e_perr, e_data}; end
    if (!RST && o_valid) begin o_cnt++; o_word = {o_ferr, o_perr, o_data}; end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic idle(input int n);
    rxd_n = 1'b1;
    rxd_p = 1'b1;
    cyc(n);
  endtask

  task automatic send_bits(input logic [11:0] bits, input int nbits, input int gbit, input bit on_p);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 16; c++) begin
        logic b;
        b = bits[i];
        if (i == gbit && c == 8) b = ~b;
        if (on_p) rxd_p = b; else rxd_n = b;
        cyc(1);
      end
    end
  endtask

  task automatic frame_n(input logic [7:0] d, input logic stop, input int gbit);
    send_bits({2'b11, stop, d, 1'b0}, 10, gbit, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) cyc(1);
    chk(tag, sb.size(), 0);
  endtask

  int base;

  initial begin
    RST = 1'b1;
    rxd_n = 1'b1;
    rxd_p = 1'b1;
    rx_ready_n = 1'b1;
    rx_ready_p = 1'b1;
    cyc(4);
    chk("rst_valid", n_valid, 0);
    chk("rst_data", n_data, 0);
    chk("rst_perr", n_perr, 0);
    chk("rst_ferr", n_ferr, 0);
    chk("rst_ovr", n_ovr, 0);
    chk("rst_busy", n_busy, 0);
    RST = 1'b0;
    idle(20);

    // 8N1 basic word
    sb.push_back(10'h041);
    frame_n(8'h41, 1'b1, -1);
    idle(20);
    drain("drain_41");
    chk("ovr_41", ovr_cnt, 0);

    // 0x41 with even parity bit 0 into the even and odd receivers
    send_bits({1'b1, 1'b1, 1'b0, 8'h41, 1'b0}, 11, -1, 1'b1);
    idle(20);
    chk("even_cnt", e_cnt, 1);
    chk("even_word", e_word, 10'h041);
    chk("odd_cnt", o_cnt, 1);
    chk("odd_word", o_word, 10'h141);
    chk("par_idle", {e_busy, o_busy, e_ovr, o_ovr}, 0);

    // Framing error then clean frame
    sb.push_back(10'h255);
    frame_n(8'h55, 1'b0, -1);
    idle(20);
    sb.push_back(10'h0AA);
    frame_n(8'hAA, 1'b1, -1);
    idle(20);
    drain("drain_ferr");

    // 4-cycle glitch on idle line is a false start
    rxd_n = 1'b0;
    cyc(4);
    rxd_n = 1'b1;
    cyc(2);
    chk("glitch_busy_hi", n_busy, 1);
    cyc(30);
    chk("glitch_busy_lo", n_busy, 0);
    chk("glitch_no_word", sb.size(), 0);

    // Single-cycle glitch at mid data bit 3 of 0x00
    sb.push_back(10'h000);
    frame_n(8'h00, 1'b1, 4);
    idle(20);
    drain("drain_vote");

    // Overrun: five words into a four-deep FIFO with the consumer stalled
    rx_ready_n = 1'b0;
    base = ovr_cnt;
    for (int w = 1; w <= 5; w++) begin
      if (w <= 4) sb.push_back(10'(w));
      frame_n(8'(w), 1'b1, -1);
      idle(4);
    end
    idle(10);
    chk("full_valid", n_valid, 1);
    chk("full_hold_data", n_data, 8'h01);
    chk("ovr_once", ovr_cnt - base, 1);
    rx_ready_n = 1'b1;
    idle(10);
    drain("drain_fifo");
    chk("fifo_empty", n_valid, 0);

    // Reset mid-DATA with two words queued
    rx_ready_n = 1'b0;
    frame_n(8'h11, 1'b1, -1);
    idle(4);
    frame_n(8'h22, 1'b1, -1);
    idle(4);
    send_bits({2'b11, 1'b1, 8'h33, 1'b0}, 4, -1, 1'b0);
    chk("pre_rst_valid", n_valid, 1);
    chk("pre_rst_busy", n_busy, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_valid", n_valid, 0);
    chk("async_data", n_data, 0);
    chk("async_busy", n_busy, 0);
    chk("async_flags", {n_perr, n_ferr, n_ovr}, 0);
    cyc(2);
    RST = 1'b0;
    rx_ready_n = 1'b1;
    idle(20);
    chk("post_rst_valid", n_valid, 0);
    sb.push_back(10'h07E);
    frame_n(8'h7E, 1'b1, -1);
    idle(20);
    drain("drain_7e");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
